pci_initiator: RTL and testbench
================================

// Module: pci_initiator
// PURPOSE
//  Simplified 32-bit PCI bus master: the initiator end of the Device_new target bus.
//  Converts a user request (cmd, addr, burst length) into address phase plus burst data phases.
//  Drives FRAME/IRDY/CBE/AD and samples TRDY/DEVSEL. Returns read data and completion/abort status.
//  Sits between the user request logic and the shared PCI bus, alongside the target devices.
// PARAMETERS
//  MAX_BURST       8   max data phases per transaction (burst_len clamped to this)
//  DEVSEL_TIMEOUT  5   clocks after address phase to wait for DEVSEL before master abort
// PORTS
//  CLK        in     1   bus clock; all bus signals driven/sampled on posedge
//  REST       in     1   reset, asynchronous, active-low
//  FRAME      out    1   PCI FRAME#, active-low
//  AD         inout  32  PCI address/data; hi-Z when not driving
//  CBE        out    4   PCI C/BE#: command in address phase, byte enables (4'b0000) in data phases
//  IRDY       out    1   PCI IRDY#, active-low
//  TRDY       in     1   PCI TRDY#, active-low
//  DEVSEL     in     1   PCI DEVSEL#, active-low
//  start      in     1   request pulse; accepted only when busy=0
//  cmd        in     4   PCI command; cmd[0]=1 write (4'b0111), 0 read (4'b0110)
//  addr       in     32  start address
//  burst_len  in     4   data phases; 0 treated as 1, >MAX_BURST clamped
//  wr_data    in     32  write word; valid at start, next word valid cycle after wr_ready
//  wr_ready   out    1   1-clk pulse: current write word consumed
//  rd_data    out    32  read word captured on completed read data phase
//  rd_valid   out    1   1-clk pulse with rd_data
//  busy       out    1   transaction in progress (start..done/abort)
//  done       out    1   1-clk pulse: all data phases completed
//  abort      out    1   1-clk pulse: master abort (no DEVSEL)
// BEHAVIOUR
//  Reset (REST=0, async): FRAME=1, IRDY=1, CBE=4'hF, AD hi-Z, all user outputs 0, state IDLE.
//  States: IDLE -> ADDR -> DATA -> TURN -> IDLE; ADDR/DATA -> ABORT -> TURN on timeout.
//  IDLE: start & !busy latches cmd/addr/len; busy=1 next edge; start while busy is ignored.
//  ADDR (1 clk): FRAME=0, AD=addr, CBE=cmd, IRDY=1.
//  DATA: IRDY=0, CBE=4'b0000. Write: AD=wr_data. Read: AD hi-Z from first clk after ADDR.
//   Phase completes on a posedge sampling IRDY=0 & TRDY=0 & DEVSEL=0.
//   TRDY=0 with DEVSEL=1 is not a completion. Wait states (TRDY=1) hold all outputs.
//   Write completion: wr_ready pulse; AD loads the next wr_data one clk later.
//   Read completion: rd_data=AD, rd_valid pulse same edge.
//   FRAME=1 while the final phase is pending (remaining==1), also for len=1.
//  TURN (1 clk) after final completion: FRAME=1, IRDY=1, AD hi-Z, CBE=4'hF; done pulse; busy=0.
//  Latency: len=1, zero-wait write: start edge to done pulse = 4 clocks.
//  DEVSEL counter starts at ADDR exit. Counter reaching DEVSEL_TIMEOUT with DEVSEL still 1 -> ABORT.
//   ABORT (1 clk): FRAME=1, IRDY=0. Then TURN with abort pulse instead of done; no more wr_ready/rd_valid.
//  Reset mid-transaction: bus released at once; no done/abort pulse.
// CONFIGURATION
//  PCI_INIT_TIMEOUT_EN defined: master-abort timeout active as described.
//  Undefined: no counter, ABORT unreachable; waits indefinitely for DEVSEL; abort tied 0.
// TESTING
//  1 Reset: REST=0 at any state -> FRAME=1, IRDY=1, CBE=F, AD=Z, busy=0 immediately.
//  2 Write len=1, addr=0000FFFF, cmd=0111, target TRDY=DEVSEL=0 from 1st data clk
//    -> ADDR AD=0000FFFF/CBE=0111, FRAME=1 in data clk, wr_ready once, done 4 clks after start.
//  3 Read len=4, target inserts 2 wait states on phase 2 -> 4 rd_valid pulses, correct words;
//    FRAME rises in phase-4 clk; IRDY held 0 across the wait states.
//  4 Write len=0 -> exactly 1 data phase; len=15 with MAX_BURST=8 -> exactly 8 wr_ready.
//  5 With PCI_INIT_TIMEOUT_EN, DEVSEL held 1 -> abort pulse 5 clks after ADDR, no done;
//    without the macro -> busy stays 1, abort stays 0.
//  6 start asserted while busy -> ignored, current transfer intact; reset mid-burst -> bus idle, no done.

Source files
------------

// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - simplified 32-bit PCI initiator: address phase plus burst data phases
// Define PCI_INIT_TIMEOUT_EN to enable the DEVSEL master-abort timeout.
module pci_initiator #(
  parameter int MAX_BURST      = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        CLK,
  input  logic        REST,
  output logic        FRAME,
  inout  wire  [31:0] AD,
  output logic [3:0]  CBE,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [3:0]  burst_len,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        abort
);
  localparam logic [3:0] MAX_LEN = 4'(MAX_BURST);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ABORT, S_TURN} state_t;

  state_t      state_q, state_d;
  logic        frame_q, frame_d, irdy_q, irdy_d;
  logic        ad_oe_q, ad_oe_d, is_wr_q, is_wr_d, reload_q, reload_d;
  logic [3:0]  cbe_q, cbe_d, rem_q, rem_d, len_eff;
  logic [31:0] ad_q, ad_d, rd_data_q, rd_data_d;
  logic        wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        complete;
`ifdef PCI_INIT_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(DEVSEL_TIMEOUT - 1);
  logic        devsel_seen_q, devsel_seen_d, end_abort_q, end_abort_d, abort_q, abort_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        timeout;
`else
  wire         unused_timeout = |DEVSEL_TIMEOUT;
`endif

  assign len_eff  = (burst_len == 4'd0) ? 4'd1 : ((burst_len > MAX_LEN) ? MAX_LEN : burst_len);
  assign complete = (state_q == S_DATA) && !irdy_q && !TRDY && !DEVSEL;
`ifdef PCI_INIT_TIMEOUT_EN
  assign timeout  = (state_q == S_DATA) && !devsel_seen_q && DEVSEL && (dcnt_q == TO_LAST);
`endif

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    irdy_d     = irdy_q;
    cbe_d      = cbe_q;
    ad_d       = ad_q;
    ad_oe_d    = ad_oe_q;
    is_wr_d    = is_wr_q;
    reload_d   = reload_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    wr_ready_d = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef PCI_INIT_TIMEOUT_EN
    devsel_seen_d = devsel_seen_q;
    end_abort_d   = end_abort_q;
    dcnt_d        = dcnt_q;
    abort_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          state_d  = S_ADDR;
          frame_d  = 1'b0;
          irdy_d   = 1'b1;
          cbe_d    = cmd;
          ad_d     = addr;
          ad_oe_d  = 1'b1;
          is_wr_d  = cmd[0];
          rem_d    = len_eff;
          reload_d = 1'b0;
          busy_d   = 1'b1;
`ifdef PCI_INIT_TIMEOUT_EN
          dcnt_d        = 4'd0;
          devsel_seen_d = 1'b0;
          end_abort_d   = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        irdy_d  = 1'b0;
        cbe_d   = 4'b0000;
        frame_d = (rem_q == 4'd1);
        ad_d    = wr_data;
        ad_oe_d = is_wr_q;
      end
      S_DATA: begin
`ifdef PCI_INIT_TIMEOUT_EN
        if (!DEVSEL) devsel_seen_d = 1'b1;
        else if (!devsel_seen_q) dcnt_d = dcnt_q + 4'd1;
        if (timeout) begin
          state_d = S_ABORT;
          frame_d = 1'b1;
          irdy_d  = 1'b0;
          ad_oe_d = 1'b0;
        end else
`endif
        // A write spends one initiator wait clock reloading AD with the next word.
        if (reload_q) begin
          ad_d     = wr_data;
          irdy_d   = 1'b0;
          reload_d = 1'b0;
          frame_d  = (rem_q == 4'd1);
        end else if (complete) begin
          if (is_wr_q) begin
            wr_ready_d = 1'b1;
          end else begin
            rd_data_d  = AD;
            rd_valid_d = 1'b1;
          end
          if (rem_q == 4'd1) begin
            state_d = S_TURN;
            frame_d = 1'b1;
            irdy_d  = 1'b1;
            ad_oe_d = 1'b0;
            cbe_d   = 4'hF;
          end else begin
            rem_d = rem_q - 4'd1;
            if (is_wr_q) begin
              reload_d = 1'b1;
              irdy_d   = 1'b1;
            end else begin
              frame_d = (rem_q == 4'd2);
            end
          end
        end
      end
      S_ABORT: begin
        state_d = S_TURN;
        frame_d = 1'b1;
        irdy_d  = 1'b1;
        ad_oe_d = 1'b0;
        cbe_d   = 4'hF;
`ifdef PCI_INIT_TIMEOUT_EN
        end_abort_d = 1'b1;
`endif
      end
      S_TURN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
`ifdef PCI_INIT_TIMEOUT_EN
        if (end_abort_q) abort_d = 1'b1;
        else done_d = 1'b1;
`else
        done_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      state_q    <= S_IDLE;
      frame_q    <= 1'b1;
      irdy_q     <= 1'b1;
      cbe_q      <= 4'hF;
      ad_q       <= 32'h0;
      ad_oe_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      reload_q   <= 1'b0;
      rem_q      <= 4'd0;
      rd_data_q  <= 32'h0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PCI_INIT_TIMEOUT_EN
      devsel_seen_q <= 1'b0;
      end_abort_q   <= 1'b0;
      dcnt_q        <= 4'd0;
      abort_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      irdy_q     <= irdy_d;
      cbe_q      <= cbe_d;
      ad_q       <= ad_d;
      ad_oe_q    <= ad_oe_d;
      is_wr_q    <= is_wr_d;
      reload_q   <= reload_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PCI_INIT_TIMEOUT_EN
      devsel_seen_q <= devsel_seen_d;
      end_abort_q   <= end_abort_d;
      dcnt_q        <= dcnt_d;
      abort_q       <= abort_d;
`endif
    end
  end

  assign AD       = ad_oe_q ? ad_q : {32{1'bz}};
  assign FRAME    = frame_q;
  assign IRDY     = irdy_q;
  assign CBE      = cbe_q;
  assign wr_ready = wr_ready_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef PCI_INIT_TIMEOUT_EN
  assign abort    = abort_q;
`else
  assign abort    = 1'b0;
`endif
endmodule

// File: tb/tb_pci_initiator.sv
// tb/tb_pci_initiator.sv - self-checking bench: PCI target model plus transaction-level scoreboard
module tb_pci_initiator;
  logic        CLK = 1'b0;
  logic        REST = 1'b0;
  logic        FRAME, IRDY, TRDY, DEVSEL, start, wr_ready, rd_valid, busy, done, abort;
  logic [3:0]  CBE, cmd, burst_len;
  logic [31:0] addr, wr_data, rd_data;
  wire  [31:0] AD;
  logic        tgt_drive;
  logic [31:0] tgt_data;

  logic [31:0] wq [16];
  logic [31:0] rq [16];
  int          waits [16];
  int          exp_n = 1;
  bit          is_wr = 1'b0;
  bit          dv_en = 1'b1;

  bit          in_txn = 1'b0;
  int          phase = 0, wcnt = 0, wr_idx = 0, rd_idx = 0;
  int          n_wr_ready = 0, n_rd_valid = 0, n_done = 0, n_abort = 0, n_addr = 0;
  int          n_wait = 0, n_dly = 0, n_abrt = 0, wd_err = 0, rd_err = 0, frame_err = 0;
  logic [31:0] cap_ad = 32'h0;
  logic [3:0]  cap_cbe = 4'h0;

  int n_pass = 0, n_total = 0;

  pci_initiator dut (
    .CLK(CLK), .REST(REST), .FRAME(FRAME), .AD(AD), .CBE(CBE), .IRDY(IRDY),
    .TRDY(TRDY), .DEVSEL(DEVSEL), .start(start), .cmd(cmd), .addr(addr),
    .burst_len(burst_len), .wr_data(wr_data), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .abort(abort)
  );

  assign AD      = (tgt_drive && REST) ? tgt_data : {32{1'bz}};
  assign wr_data = wq[wr_idx[3:0]];

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Target side: decides TRDY/DEVSEL for the coming edge and scores each completed phase.
  always @(negedge CLK) begin
    tgt_drive = 1'b0;
    TRDY      = 1'b1;
    DEVSEL    = 1'b1;
    if (!REST) begin
      in_txn = 1'b0;
    end else begin
      if (wr_ready) begin n_wr_ready++; wr_idx++; end
      if (rd_valid) begin
        n_rd_valid++;
        if (rd_data !== rq[rd_idx[3:0]]) rd_err++;
        rd_idx++;
      end
      if (done) n_done++;
      if (abort) n_abort++;
      if (!in_txn) begin
        if (!FRAME && IRDY) begin
          in_txn = 1'b1; n_addr++; cap_ad = AD; cap_cbe = CBE;
          phase = 0; wcnt = 0; wr_idx = 0; rd_idx = 0;
        end
      end else if (FRAME && IRDY) begin
        in_txn = 1'b0;
      end else if (!IRDY) begin
        if (!dv_en) begin
          if (FRAME) n_abrt++;
          else n_dly++;
        end else begin
          DEVSEL = 1'b0;
          if (wcnt < waits[phase[3:0]]) begin
            wcnt++; n_wait++;
          end else begin
            TRDY = 1'b0;
            if (FRAME !== (phase == exp_n - 1)) frame_err++;
            if (is_wr) begin
              if (AD !== wq[phase[3:0]]) wd_err++;
            end else begin
              tgt_drive = 1'b1; tgt_data = rq[phase[3:0]];
            end
            phase++; wcnt = 0;
          end
        end
      end
    end
  end

  // wmode: 0 no waits, 1 two waits on phase 2, 2 random 0..2 waits per phase
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [3:0] len,
                         input int wmode, input bit poke, output int lat);
    int d0, ab0, w0, r0, ad0, nw0, we0, re0, fe0, ew;
    logic [3:0] c;
    exp_n = (len == 4'd0) ? 1 : ((len > 4'd8) ? 8 : int'(len));
    is_wr = wr; dv_en = 1'b1; ew = 0;
    c = wr ? 4'b0111 : 4'b0110;
    for (int i = 0; i < 16; i++) begin
      wq[i] = $urandom; rq[i] = $urandom;
      waits[i] = (wmode == 2) ? int'($urandom_range(2, 0)) : ((wmode == 1 && i == 1) ? 2 : 0);
      if (i < exp_n) ew += waits[i];
    end
    d0 = n_done; ab0 = n_abort; w0 = n_wr_ready; r0 = n_rd_valid; ad0 = n_addr;
    nw0 = n_wait; we0 = wd_err; re0 = rd_err; fe0 = frame_err;
    start = 1'b1; cmd = c; addr = a; burst_len = len;
    lat = 0;
    while ((n_done == d0) && (n_abort == ab0) && (lat < 300)) begin
      @(negedge CLK); #1;
      lat++;
      start = poke && (lat == 3);
      if (poke && lat == 3) addr = ~a;
    end
    start = 1'b0;
    @(negedge CLK); #1;
    check("txn_bounded", lat < 300, 1);
    check("addr_ad", cap_ad, a);
    check("addr_cbe", cap_cbe, c);
    check("addr_phases", n_addr - ad0, 1);
    check("done_cnt", n_done - d0, 1);
    check("abort_cnt", n_abort - ab0, 0);
    check("wr_ready_cnt", n_wr_ready - w0, wr ? exp_n : 0);
    check("rd_valid_cnt", n_rd_valid - r0, wr ? 0 : exp_n);
    check("wait_states", n_wait - nw0, ew);
    check("wr_words", wd_err - we0, 0);
    check("rd_words", rd_err - re0, 0);
    check("frame_timing", frame_err - fe0, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int lat, d0, ab0, w0;
    start = 1'b0; cmd = 4'h0; addr = 32'h0; burst_len = 4'h0;
    for (int i = 0; i < 16; i++) begin wq[i] = 32'h0; rq[i] = 32'h0; waits[i] = 0; end
    repeat (3) @(negedge CLK);
    #1;
    check("rst_frame", FRAME, 1);
    check("rst_irdy", IRDY, 1);
    check("rst_cbe", CBE, 4'hF);
    check("rst_ad_z", (AD === {32{1'bz}}), 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {wr_ready, rd_valid, done, abort}, 4'b0000);
    REST = 1'b1;
    @(negedge CLK); #1;

    run_txn(1'b1, 32'h0000FFFF, 4'd1, 0, 1'b0, lat);
    check("wr1_latency", lat, 4);
    run_txn(1'b0, $urandom, 4'd4, 1, 1'b0, lat);
    run_txn(1'b1, $urandom, 4'd0, 0, 1'b0, lat);
    run_txn(1'b1, $urandom, 4'd15, 2, 1'b0, lat);
    run_txn(1'b1, $urandom, 4'd4, 1, 1'b1, lat);
    for (int k = 0; k < 16; k++)
      run_txn(1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)), 2, 1'($urandom_range(1, 0)), lat);

    // No target claims the transfer.
    is_wr = 1'b1; dv_en = 1'b0; exp_n = 4;
    d0 = n_done; ab0 = n_abort; w0 = n_wr_ready;
    lat = n_dly;
    start = 1'b1; cmd = 4'b0111; addr = $urandom; burst_len = 4'd4;
    @(negedge CLK); #1;
    start = 1'b0;
`ifdef PCI_INIT_TIMEOUT_EN
    for (int t = 0; t < 100 && n_abort == ab0; t++) begin
      @(negedge CLK); #1;
    end
    @(negedge CLK); #1;
    check("abort_pulse", n_abort - ab0, 1);
    check("abort_no_done", n_done - d0, 0);
    check("abort_no_wr_ready", n_wr_ready - w0, 0);
    check("abort_wait_clks", n_dly - lat, 5);
    check("abort_state_clks", n_abrt, 1);
    check("abort_busy", busy, 0);
`else
    repeat (30) @(negedge CLK);
    #1;
    check("nodevsel_busy", busy, 1);
    check("nodevsel_abort", n_abort - ab0, 0);
    check("nodevsel_done", n_done - d0, 0);
    REST = 1'b0;
    @(negedge CLK); #1;
    REST = 1'b1;
    @(negedge CLK); #1;
`endif

    // Reset in the middle of a read burst.
    is_wr = 1'b0; dv_en = 1'b1; exp_n = 8;
    for (int i = 0; i < 16; i++) waits[i] = 1;
    d0 = n_done; ab0 = n_abort;
    start = 1'b1; cmd = 4'b0110; addr = $urandom; burst_len = 4'd8;
    @(negedge CLK); #1;
    start = 1'b0;
    repeat (6) @(negedge CLK);
    #3;
    REST = 1'b0;
    #1;
    check("midrst_frame", FRAME, 1);
    check("midrst_irdy", IRDY, 1);
    check("midrst_cbe", CBE, 4'hF);
    check("midrst_ad_z", (AD === {32{1'bz}}), 1);
    check("midrst_busy", busy, 0);
    @(negedge CLK); #1;
    REST = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    check("midrst_no_done", n_done - d0, 0);
    check("midrst_no_abort", n_abort - ab0, 0);
    check("midrst_idle", {busy, FRAME, IRDY}, 3'b011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
